// File: rtl/parity_frame_accumulator.sv
// rtl/parity_frame_accumulator.sv - per-lane parity accumulator over framed input words
// Optional feature macro: PARITY_FRAME_CHECK_EN (adds exp_parity / out_err / err_count)
module parity_frame_accumulator #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int FRAME_LEN = 16,
  parameter int ODD       = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES-1:0]               out_parity,
  output logic [$clog2(FRAME_LEN+1)-1:0] out_words
`ifdef PARITY_FRAME_CHECK_EN
  ,
  input  logic [LANES-1:0]               exp_parity,
  output logic                           out_err,
  output logic [7:0]                     err_count
`endif
);

  localparam int LW = WIDTH / LANES;
  localparam int CW = $clog2(FRAME_LEN + 1);

  // Inverting every lane turns the even-parity accumulators into odd parity.
  localparam logic [LANES-1:0] ODD_MASK = (ODD != 0) ? {LANES{1'b1}} : {LANES{1'b0}};
  localparam logic [CW-1:0]    LEN_MAX  = CW'(FRAME_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       r_state;
  logic [LANES-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic [LANES-1:0] r_out_parity;
  logic [CW-1:0]    r_out_words;

  logic [LANES-1:0] w_lane_par;
  logic [LANES-1:0] w_acc_next;
  logic [CW-1:0]    w_count_inc;
  logic             w_accept;
  logic             w_close;
  logic             w_take;

  // Reduce each lane slice of the incoming word to a single parity bit.
  always_comb begin
    w_lane_par = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_par[k] = ^in_data[k*LW +: LW];
    end
  end

  // Handshake qualification and frame-close detection (explicit last or full frame).
  always_comb begin
    in_ready    = !reset && (r_state != S_HOLD);
    w_accept    = in_valid && in_ready;
    w_take      = r_out_valid && out_ready;
    w_acc_next  = r_acc ^ w_lane_par;
    w_count_inc = r_count + CW'(1);
    w_close     = w_accept && (in_last || (w_count_inc == LEN_MAX));
  end

  // Frame state: open on the first word, hold after close, release on result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_close) begin
            r_state <= S_HOLD;
          end else if (w_accept) begin
            r_state <= S_ACCUM;
          end
        end
        S_HOLD: begin
          if (w_take) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane accumulators and word count; cleared only once the result has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_take) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_acc   <= w_acc_next;
      r_count <= w_count_inc;
    end
  end

  // Result registers: captured with the closing word, frozen until the sink takes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_parity <= '0;
      r_out_words  <= '0;
    end else if (w_close) begin
      r_out_valid  <= 1'b1;
      r_out_parity <= w_acc_next ^ ODD_MASK;
      r_out_words  <= w_count_inc;
    end else if (w_take) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_parity = r_out_parity;
  assign out_words  = r_out_words;

`ifdef PARITY_FRAME_CHECK_EN
  logic       r_out_err;
  logic [7:0] r_err_count;

  // Compare against the expectation presented with the closing word; count bad frames on handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_close) begin
        r_out_err <= ((w_acc_next ^ ODD_MASK) != exp_parity);
      end
      if (w_take && r_out_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign out_err   = r_out_err;
  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_parity_frame_accumulator.sv
// tb/tb_parity_frame_accumulator.sv - self-checking bench for parity_frame_accumulator
module tb_parity_frame_accumulator;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic [3:0]  exp_parity;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [3:0]  out_parity0, out_parity1;
  logic [2:0]  out_words0, out_words1;
`ifdef PARITY_FRAME_CHECK_EN
  logic        out_err0, out_err1;
  logic [7:0]  err_count0, err_count1;
`endif

  always #5 clk = ~clk;

  parity_frame_accumulator #(.WIDTH(32), .LANES(4), .FRAME_LEN(FL), .ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_parity(out_parity0), .out_words(out_words0)
`ifdef PARITY_FRAME_CHECK_EN
    , .exp_parity(exp_parity), .out_err(out_err0), .err_count(err_count0)
`endif
  );

  parity_frame_accumulator #(.WIDTH(32), .LANES(4), .FRAME_LEN(FL), .ODD(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_parity(out_parity1), .out_words(out_words1)
`ifdef PARITY_FRAME_CHECK_EN
    , .exp_parity(exp_parity), .out_err(out_err1), .err_count(err_count1)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;

  bit          m_hold;
  logic [31:0] q[$];
  logic [3:0]  m_par0, m_par1;
  int          m_words;
  bit          m_err0, m_err1;
  int          m_cnt0, m_cnt1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] frame_par(input bit odd);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) begin
      int ones = 0;
      foreach (q[i]) ones += $countones(q[i][8*k +: 8]);
      p[k] = ((ones % 2) == 1) ^ odd;
    end
    return p;
  endfunction

  function automatic logic [3:0] word_par(input logic [31:0] w);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = ($countones(w[8*k +: 8]) % 2) == 1;
    return p;
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [31:0] d, input bit l,
                       input bit ordy, input logic [3:0] e);
    reset = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy; exp_parity = e;
    @(posedge clk);
    if (r) begin
      m_hold = 0; q.delete(); m_err0 = 0; m_err1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 0;
        if (m_err0 && m_cnt0 < 255) m_cnt0++;
        if (m_err1 && m_cnt1 < 255) m_cnt1++;
      end
    end else if (v) begin
      q.push_back(d);
      if (l || q.size() == FL) begin
        m_par0  = frame_par(0);
        m_par1  = frame_par(1);
        m_words = q.size();
        m_err0  = (m_par0 != e);
        m_err1  = (m_par1 != e);
        m_hold  = 1;
        q.delete();
      end
    end
    @(negedge clk);
    check("in_ready0", in_ready0, !reset && !m_hold);
    check("in_ready1", in_ready1, !reset && !m_hold);
    check("out_valid0", out_valid0, m_hold);
    check("out_valid1", out_valid1, m_hold);
    if (m_hold) begin
      check("out_parity0", out_parity0, m_par0);
      check("out_parity1", out_parity1, m_par1);
      check("out_words0", out_words0, m_words);
      check("out_words1", out_words1, m_words);
`ifdef PARITY_FRAME_CHECK_EN
      check("out_err0", out_err0, m_err0);
      check("out_err1", out_err1, m_err1);
`endif
    end
`ifdef PARITY_FRAME_CHECK_EN
    check("err_count0", err_count0, m_cnt0);
    check("err_count1", err_count1, m_cnt1);
`endif
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0; exp_parity = 0;

    // Reset, with a stray word offered while reset is held.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h1234_5678, 1, 1, 0);
    check("rst_parity0", out_parity0, 0);
    check("rst_words0", out_words0, 0);
    check("rst_parity1", out_parity1, 0);

    // Single-word frame.
    cycle(0, 1, 32'h0103_0700, 1, 0, 4'b1010);
    check("single_par0", out_parity0, 4'b1010);
    check("single_par1", out_parity1, 4'b0101);
    check("single_words", out_words0, 1);
    cycle(0, 0, 0, 0, 1, 0);

    // Three-word frame, even and odd parity.
    cycle(0, 1, 32'h0000_00FF, 0, 0, 0);
    cycle(0, 1, 32'h0000_0001, 0, 0, 0);
    cycle(0, 1, 32'h0000_0001, 1, 0, 0);
    check("three_par0", out_parity0, 4'b0000);
    check("three_par1", out_parity1, 4'b1111);
    check("three_words", out_words0, 3);
    cycle(0, 0, 0, 0, 1, 0);

    // Forced close at FRAME_LEN; HOLD-state words are ignored.
    cycle(0, 1, 32'h0000_0001, 0, 0, 0);
    cycle(0, 1, 32'h0000_0100, 0, 0, 0);
    cycle(0, 1, 32'h0001_0000, 0, 0, 0);
    cycle(0, 1, 32'h0100_0000, 0, 0, 0);
    check("forced_words", out_words0, 4);
    check("forced_par0", out_parity0, 4'b1111);
    cycle(0, 1, 32'hFFFF_FFFE, 1, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFE, 1, 1, 0);
    cycle(0, 1, 32'h0000_0003, 0, 0, 0);
    cycle(0, 1, 32'h0000_0000, 1, 0, 0);
    check("fifth_words", out_words0, 2);
    check("fifth_par0", out_parity0, 4'b0000);
    cycle(0, 0, 0, 0, 1, 0);

    // Backpressure: result held for five cycles while new words are offered.
    cycle(0, 1, 32'h8000_0001, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, $urandom, 1, 0, 0);
    check("bp_par0", out_parity0, 4'b1001);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset mid-frame discards the partial frame.
    cycle(0, 1, 32'hFFFF_0F0F, 0, 0, 0);
    cycle(0, 1, 32'h0000_0010, 0, 0, 0);
    cycle(1, 1, 32'h0000_0001, 1, 1, 0);
    check("mid_rst_valid", out_valid0, 0);
    cycle(0, 1, 32'h0000_0001, 1, 0, 0);
    check("mid_rst_par0", out_parity0, 4'b0001);
    check("mid_rst_words", out_words0, 1);
    cycle(0, 0, 0, 0, 1, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6), 4'($urandom));
    end
    cycle(0, 0, 0, 0, 1, 0);

`ifdef PARITY_FRAME_CHECK_EN
    // Checker: 300 mismatching frames saturate err_count, then a matching frame.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = $urandom;
      cycle(0, 1, d, 1, 0, ~word_par(d));
      check("chk_err", out_err0, 1);
      cycle(0, 0, 0, 0, 1, 0);
    end
    check("chk_sat", err_count0, 255);
    cycle(0, 1, 32'h0103_0700, 1, 0, 4'b1010);
    check("chk_match", out_err0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("chk_hold", err_count0, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_accumulator.md
PARITY_FRAME_ACCUMULATOR -- requirements
Module: parity_frame_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the input data word width in bits.
REQ-002 SHALL have parameter LANES, default 4, meaning the number of independent parity lanes; WIDTH % LANES == 0, lane width LW = WIDTH/LANES.
REQ-003 SHALL have parameter FRAME_LEN, default 16, meaning the maximum number of words per frame (≥1).
REQ-004 SHALL have parameter ODD, default 0, meaning 0 = even parity and 1 = odd parity.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning the input word is valid.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-009 SHALL have port in_data, input, WIDTH bits, the data word.
REQ-010 SHALL have port in_last, input, 1 bit, marking the final word of a frame.
REQ-011 SHALL have port out_valid, output, 1 bit, meaning a frame result is available.
REQ-012 SHALL have port out_ready, input, 1 bit, meaning the sink accepts the result.
REQ-013 SHALL have port out_parity, output, LANES bits, the per-lane frame parity.
REQ-014 SHALL have port out_words, output, $clog2(FRAME_LEN+1) bits, the number of words in the frame.

Function
REQ-015 SHALL transfer an input word only when in_valid && in_ready, and a result only when out_valid && out_ready.
REQ-016 SHALL implement the states IDLE (no words accumulated), ACCUM (at least one word accumulated, frame open) and HOLD (result presented).
REQ-017 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-018 SHALL fold each accepted word into the lane accumulators: acc[k] ^= XOR of in_data[k*LW +: LW].
REQ-019 SHALL close the frame on an accepted word with in_last = 1, or on the accepted word that makes the count equal FRAME_LEN (forced close; in_last is ignored otherwise).
REQ-020 SHALL define transitions as follows:
- IDLE→ACCUM on accept without close.
- IDLE/ACCUM→HOLD on accept with close.
- HOLD→IDLE on out handshake.
REQ-021 SHALL register the result: out_valid rises on the cycle after the closing word is accepted (latency 1); out_parity = final acc ^ {LANES{ODD}}; out_words = the word count including the closing word.
REQ-022 SHALL hold out_valid, out_parity and out_words stable while out_valid && !out_ready.
REQ-023 SHALL clear the accumulators and count when the result is taken, so that the next frame starts from zero.
REQ-024 SHALL process a single-word frame (in_last on the first word) normally, with out_words = 1.
REQ-025 SHALL ignore in_data and in_last when no transfer occurs, including a HOLD-state in_valid.

Reset
REQ-026 SHALL, when reset = 1 at a clock edge, force state IDLE, the accumulators to 0, the count to 0, out_valid = 0, out_parity = 0 and out_words = 0.
REQ-027 SHALL give reset priority over any simultaneous handshake; a partially accumulated frame or a pending result is discarded, not emitted.
REQ-028 SHALL drive in_ready = 0 during reset, and in_ready = 1 on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with macro PARITY_FRAME_CHECK_EN defined, add the following ports:
- exp_parity: input, LANES bits, sampled with the closing word.
- out_err: output, 1 bit.
- err_count: output, 8 bits.
REQ-030 SHALL, with PARITY_FRAME_CHECK_EN defined, drive out_err = (out_parity != sampled exp_parity), valid and stable alongside out_valid.
REQ-031 SHALL, with PARITY_FRAME_CHECK_EN defined, increment err_count on each out handshake with out_err = 1, saturating at 255.
REQ-032 SHALL reset out_err and err_count to 0.
REQ-033 SHALL, with PARITY_FRAME_CHECK_EN undefined, omit these ports and logic entirely, with all other behaviour identical.

Verification
REQ-034 SHALL cover a single-word frame: WIDTH=32, LANES=4, ODD=0, in_data=0x01030700 with in_last=1 → one cycle later out_valid=1, out_parity=4'b1010, out_words=1.
REQ-035 SHALL cover a three-word frame: words 0xFF, 0x01, 0x01 with in_last on the third word → out_parity=4'b0000, out_words=3; with ODD=1 → 4'b1111.
REQ-036 SHALL cover a forced close: FRAME_LEN=4, four words with in_last=0 → result after the fourth word with out_words=4; the fifth word starts a new frame.
REQ-037 SHALL cover backpressure: out_ready=0 for 5 cycles → out_valid and data stable, in_ready=0 throughout; out_ready=1 → handshake, and in_ready=1 on the next cycle.
REQ-038 SHALL cover reset mid-frame: 2 words accepted, then reset pulse → no output; the next 1-word frame of 0x00000001 gives out_parity=4'b0001, out_words=1.
REQ-039 SHALL cover the checker with PARITY_FRAME_CHECK_EN: exp_parity mismatching on 300 frames → out_err=1 each frame and err_count saturating at 255; a matching frame → out_err=0.
